// File: rtl/instr_pkg.sv
// Shared defaults and instruction field layout for the instruction prefetch queue.
// The IW-bit instruction word is split into four equal fields, opcode in the top quarter.
package instr_pkg;

    localparam int IW_DEFAULT    = 16;
    localparam int DEPTH_DEFAULT = 4;

    // Field positions, counted in field-widths from the LSB.
    localparam int FIELD_OPCODE = 3;
    localparam int FIELD_DA     = 2;
    localparam int FIELD_AA     = 1;
    localparam int FIELD_BA     = 0;

    function automatic int field_w(input int iw);
        return iw / 4;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular prefetch buffer: DEPTH words, wrap-around pointers, occupancy count.
// Push is ignored when full and pop when empty; i_clear empties the buffer at the next edge.
module instr_fifo
    import instr_pkg::*;
#(
    parameter  int IW    = IW_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [IW-1:0] i_data,
    input  logic          i_pop,
    output logic [IW-1:0] o_head,
    output logic [CW-1:0] o_count
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full  && !i_clear;
    assign w_pop   = i_pop  && !w_empty && !i_clear;

    // NOTE: storage has no reset; a slot is only ever read after it has been written,
    // so the count and pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_queue.sv
// Instruction prefetch queue feeding an instruction register with opcode/DA/AA/BA field decode.
// Define IR_BYPASS_EN to let a word fetched into an empty queue load IR in the same edge as IL.
module instruction_queue
    import instr_pkg::*;
#(
    parameter int IW    = IW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [IW-1:0]             in_word,
    output logic                      in_ready,
    input  logic                      IL,
    input  logic                      flush,
    output logic [IW-1:0]             IR,
    output logic                      ir_valid,
    output logic [field_w(IW)-1:0]    opcode,
    output logic [field_w(IW)-1:0]    DA,
    output logic [field_w(IW)-1:0]    AA,
    output logic [field_w(IW)-1:0]    BA,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int FW = field_w(IW);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0] r_ir;
    logic          r_ir_valid;

    logic [IW-1:0] w_head;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    assign w_empty  = (w_count == '0);
    assign in_ready = (w_count < CW'(DEPTH));

`ifdef IR_BYPASS_EN
    assign w_bypass = w_empty && in_valid && IL && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word goes straight to IR and must not also be enqueued.
    assign w_push = in_valid && in_ready && !flush && !w_bypass;
    assign w_pop  = IL && !w_empty && !flush;

    instr_fifo #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_data  (in_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // flush and a bubble only invalidate IR; its contents are kept for inspection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (flush) begin
            r_ir_valid <= 1'b0;
        end else if (w_bypass) begin
            r_ir       <= in_word;
            r_ir_valid <= 1'b1;
        end else if (w_pop) begin
            r_ir       <= w_head;
            r_ir_valid <= 1'b1;
        end else if (IL) begin
            r_ir_valid <= 1'b0;
        end
    end

    assign IR       = r_ir;
    assign ir_valid = r_ir_valid;
    assign count    = w_count;

    assign opcode = r_ir[FIELD_OPCODE*FW +: FW];
    assign DA     = r_ir[FIELD_DA*FW     +: FW];
    assign AA     = r_ir[FIELD_AA*FW     +: FW];
    assign BA     = r_ir[FIELD_BA*FW     +: FW];

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: a stimulus process queues expected IR loads,
// a monitor process compares IR and its fields after every IL edge.
module tb_instruction_queue;
    import instr_pkg::*;

    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int FW    = IW / 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_word  = '0;
    logic          IL       = 1'b0;
    logic          flush    = 1'b0;
    logic          in_ready;
    logic [IW-1:0] IR;
    logic          ir_valid;
    logic [FW-1:0] opcode, DA, AA, BA;
    logic [CW-1:0] count;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] word;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] model_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    instruction_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_word  (in_word),
        .in_ready (in_ready),
        .IL       (IL),
        .flush    (flush),
        .IR       (IR),
        .ir_valid (ir_valid),
        .opcode   (opcode),
        .DA       (DA),
        .AA       (AA),
        .BA       (BA),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge that sampled IL (out of reset, no flush) consumes one expectation.
    logic mon_il, mon_fl, mon_rst;
    exp_t mon_e;
    always @(posedge clk) begin
        mon_il  = IL;
        mon_fl  = flush;
        mon_rst = reset;
        #1;
        if (mon_rst && mon_il && !mon_fl) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_load", 32'(1), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_ir_valid", 32'(ir_valid), 32'(mon_e.valid));
                if (mon_e.valid) begin
                    check("mon_ir",     32'(IR),     32'(mon_e.word));
                    check("mon_opcode", 32'(opcode), 32'(mon_e.word[IW-1 -: FW]));
                    check("mon_da",     32'(DA),     32'(mon_e.word[3*FW-1 -: FW]));
                    check("mon_aa",     32'(AA),     32'(mon_e.word[2*FW-1 -: FW]));
                    check("mon_ba",     32'(BA),     32'(mon_e.word[FW-1 -: FW]));
                end
            end
        end
    end

    // Drive one cycle, update the reference queue, then check occupancy after the edge.
    task automatic drive(input logic v, input logic [IW-1:0] w, input logic il, input logic fl);
        exp_t e;
        bit   byp;
        bit   push_ok;
        in_valid = v;
        in_word  = w;
        IL       = il;
        flush    = fl;
        byp      = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
`ifdef IR_BYPASS_EN
            byp = (model_q.size() == 0) && v && il;
`endif
            push_ok = v && (model_q.size() < DEPTH) && !byp;
            if (il) begin
                if (byp)                    e = '{1'b1, w};
                else if (model_q.size() > 0) e = '{1'b1, model_q.pop_front()};
                else                         e = '{1'b0, '0};
                exp_q.push_back(e);
            end
            if (push_ok) model_q.push_back(w);
        end
        @(posedge clk);
        #1;
        check("count",     32'(count),    32'(model_q.size()));
        check("in_ready",  32'(in_ready), 32'(model_q.size() < DEPTH));
        check("count_max", 32'(count <= CW'(DEPTH)), 32'(1));
    endtask

    initial begin
        int next;

        // Reset held low with a word offered: nothing moves.
        in_valid = 1'b1;
        in_word  = 16'h8006;
        #2;
        check("rst_ir",       32'(IR),       32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_count",    32'(count),    32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_ir",       32'(IR),       32'h0);
            check("rst_hold_ir_valid", 32'(ir_valid), 32'h0);
            check("rst_hold_count",    32'(count),    32'h0);
            check("rst_hold_in_ready", 32'(in_ready), 32'h1);
        end
        in_valid = 1'b0;
        reset    = 1'b1;

        // Two pushes then two loads: 8006 -> {8,0,0,6}, 1234 -> {1,2,3,4}.
        drive(1'b1, 16'h8006, 1'b0, 1'b0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        check("two_pushed", 32'(count), 32'd2);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("first_opcode", 32'(opcode), 32'h8);
        check("first_ba",     32'(BA),     32'h6);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("second_da", 32'(DA), 32'h2);
        check("second_aa", 32'(AA), 32'h3);

        // Fill to DEPTH, refuse a fifth word, then push/IL at full pops only.
        drive(1'b1, 16'h00A1, 1'b0, 1'b0);
        drive(1'b1, 16'h00A2, 1'b0, 1'b0);
        drive(1'b1, 16'h00A3, 1'b0, 1'b0);
        drive(1'b1, 16'h00A4, 1'b0, 1'b0);
        check("full_count", 32'(count),    32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h00A5, 1'b0, 1'b0);
        check("full_refuse", 32'(count), 32'd4);
        drive(1'b1, 16'h00A5, 1'b1, 1'b0);
        check("full_push_il", 32'(count), 32'd3);
        drive(1'b1, 16'h00A5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("drained_ir", 32'(IR), 32'h00A5);

        // flush wins over push and IL; IR keeps its last value.
        drive(1'b1, 16'h00B1, 1'b0, 1'b0);
        drive(1'b1, 16'h00B2, 1'b0, 1'b0);
        drive(1'b1, 16'h00B3, 1'b1, 1'b1);
        check("flush_count",    32'(count),    32'd0);
        check("flush_ir_valid", 32'(ir_valid), 32'd0);
        check("flush_ir_held",  32'(IR),       32'h00A5);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("bubble_ir_held", 32'(IR), 32'h00A5);

        // Fetch into an empty queue with IL in the same cycle.
        drive(1'b1, 16'hABCD, 1'b1, 1'b0);
`ifdef IR_BYPASS_EN
        check("byp_ir",       32'(IR),       32'hABCD);
        check("byp_ir_valid", 32'(ir_valid), 32'd1);
        check("byp_count",    32'(count),    32'd0);
`else
        check("nobyp_ir_valid", 32'(ir_valid), 32'd0);
        check("nobyp_count",    32'(count),    32'd1);
`endif
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
`ifndef IR_BYPASS_EN
        check("nobyp_ir_late", 32'(IR), 32'hABCD);
`endif

        // Stream 10 words with IL every third cycle; pointers wrap more than once.
        next = 0;
        for (int c = 0; c < 30; c++) begin
            logic v;
            v = (next < 10);
            if (v && (model_q.size() < DEPTH)) begin
                drive(1'b1, IW'(16'h5000 + next), (c % 3 == 2), 1'b0);
                next++;
            end else begin
                drive(v, IW'(16'h5000 + next), (c % 3 == 2), 1'b0);
            end
        end
        while (model_q.size() > 0) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("stream_all_sent", 32'(next), 32'd10);

        // Asynchronous reset mid-operation discards queued words immediately.
        drive(1'b1, 16'h00C1, 1'b0, 1'b0);
        drive(1'b1, 16'h00C2, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_q.delete();
        #1;
        check("async_rst_ir",       32'(IR),       32'h0);
        check("async_rst_ir_valid", 32'(ir_valid), 32'h0);
        check("async_rst_count",    32'(count),    32'h0);
        check("async_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("post_rst_no_word", 32'(ir_valid), 32'h0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        #10;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
